fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Packet-level round-robin write arbiter that shares one synchronous FIFO between NREQ producers. Each producer presents a packet as a sequence of beats with a last flag. The arbiter locks onto one producer for a whole packet, so packets never interleave in the FIFO. It sits directly in front of the FIFO write port: it drives the FIFO's write enable and data, and consumes the FIFO's full flag.

## Interface
Parameters:
- NREQ, 4, number of producers (2..16, need not be a power of 2)
- DWIDTH, 8, beat width; matches FIFO data width
- IDXW, $clog2(NREQ), width of the owner index (derived, not overridden)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-producer beat valid
- last  in  NREQ  per-producer end-of-packet flag, qualified by req
- data  in  NREQ*DWIDTH  per-producer beat; producer i occupies bits [i*DWIDTH +: DWIDTH]
- ready  out  NREQ  per-producer beat accept
- fifo_full  in  1  FIFO full flag
- fifo_wren  out  1  FIFO write enable
- fifo_din  out  DWIDTH  FIFO write data
- owner  out  IDXW  index of the producer holding the lock
- busy  out  1  high while in LOCK

## Operation
- States: IDLE, LOCK. Registers: state, owner, prio (round-robin start index).
- IDLE:
  - ready = 0; fifo_wren = 0.
  - If req != 0: pick the first i with req[i]=1, scanning prio, prio+1, … with wrap at NREQ-1 → 0.
  - Load owner = i; next state LOCK.
- LOCK:
  - ready[owner] = ~fifo_full; every other ready bit = 0.
  - fifo_wren = req[owner] & ~fifo_full; fifo_din = data[owner].
- Beat accepted when req[owner] & ready[owner].
- Accepted beat with last[owner]=1:
  - next state IDLE.
  - prio = (owner==NREQ-1) ? 0 : owner+1.
- A lock is never released without a last beat. If the owner drops req mid-packet, the arbiter stays in LOCK and all other producers wait.
- Producer rule: once req is asserted, req, last and data stay stable until the beat is accepted.
- fifo_din is don't-care when fifo_wren=0. The implementation drives data[owner] unconditionally.
- Reset values: state=IDLE, owner=0, prio=0, busy=0, ready=0, fifo_wren=0, fifo_din=data[0].
- Reset mid-packet: the arbiter returns to IDLE immediately. Any partial packet already written stays in the FIFO; the FIFO is reset by the same rstn.

## Timing
- Arbitration latency: req rises in cycle t (state IDLE) → LOCK and owner valid at t+1. The first beat can be accepted at t+1.
- Throughput in LOCK: 1 beat/cycle while ~fifo_full and the owner holds req.
- Packet turnaround: the last beat is accepted in cycle t → IDLE at t+1 (one bubble cycle) → next owner in LOCK at t+2.
- ready and fifo_wren are combinational from state, owner, req and fifo_full. There is no combinational path from req to ready.
- fifo_full high: the owner is stalled with no write. The lock and the beat are held.
- Single-beat packet (req=1, last=1 on the first beat): one cycle in LOCK.

## Structure
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, LOCK} arb_state_t
  - the function next_idx(idx, n), which implements the wrap-around increment
- Sub-module rr_pick:
  - purely combinational round-robin picker
  - inputs: req[NREQ], prio[IDXW]
  - outputs: found, idx[IDXW]
  - instantiated once.
- Top level holds the state register, owner/prio registers and the output muxing.

## Test plan
- After reset, req=4'b0000 → ready=0, fifo_wren=0, owner=0, busy=0. Assert req[2] with a 3-beat packet 0x11, 0x22, 0x33(last) → busy at the next cycle; FIFO receives 0x11, 0x22, 0x33 on three consecutive cycles; IDLE one cycle later; prio=3.
- All four producers send 1-beat packets 0xA0–0xA3 simultaneously from reset → FIFO order A0, A1, A2, A3, one write every 2 cycles. Repeat immediately → the order restarts at producer 0.
- Interleave attempt: producer 0 sends a 4-beat packet while producer 1 holds req → all four producer-0 beats precede any producer-1 beat; ready[1]=0 throughout.
- fifo_full forced high for 3 cycles mid-packet → fifo_wren=0 and ready[owner]=0 for those cycles; no beat is lost or duplicated; owner is unchanged.
- The owner drops req for 5 cycles mid-packet while producer 3 requests → still in LOCK, no writes, ready[3]=0. The packet resumes and completes, then producer 3 is granted.
- rstn pulsed low while in LOCK with owner=1 → immediately state=IDLE, busy=0, ready=0, fifo_wren=0, owner=0, prio=0. After release, normal arbitration restarts from producer 0.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the packet round-robin FIFO write arbiter.
// Holds the arbiter state encoding and the wrap-around index increment.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer/FIFO bundle seen by the write arbiter.
// master: drives req/last/data/fifo_full; slave: arbiter outputs.
interface fifo_wr_arb_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int IDXW   = $clog2(NREQ)
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        last;
  logic [NREQ*DWIDTH-1:0] data;
  logic [NREQ-1:0]        ready;
  logic                   fifo_full;
  logic                   fifo_wren;
  logic [DWIDTH-1:0]      fifo_din;
  logic [IDXW-1:0]        owner;
  logic                   busy;

  modport master (
    output req, last, data, fifo_full,
    input  ready, fifo_wren, fifo_din, owner, busy
  );

  modport slave (
    input  req, last, data, fifo_full,
    output ready, fifo_wren, fifo_din, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit from prio upward.
// Ports: req, prio in; found, idx out.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] prio,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] c;

  // Walk NREQ candidates starting at prio; index wraps at NREQ-1
  // so non-power-of-two NREQ never visits a missing producer.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = prio;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
      c = IDXW'(next_idx(int'(c), NREQ));
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-level round-robin arbiter in front of a FIFO write port.
// Ports: clk, rstn (async low), bus (slave: req/last/data/ready/fifo_*).
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DWIDTH = 8,
  localparam int IDXW   = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rstn,
  fifo_wr_arb_if.slave  bus
);

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] prio_q, prio_d;

  logic            found;
  logic [IDXW-1:0] pick;
  logic            locked;
  logic            own_req;
  logic            own_last;
  logic            accept;
  logic [NREQ-1:0] ready_c;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (bus.req),
    .prio  (prio_q),
    .found (found),
    .idx   (pick)
  );

  assign locked   = (state_q == LOCK);
  assign own_req  = bus.req[owner_q];
  assign own_last = bus.last[owner_q];
  assign accept   = locked & own_req & ~bus.fifo_full;

  // ready depends only on state/owner/full, never on req.
  always_comb begin
    ready_c = '0;
    if (locked) ready_c[owner_q] = ~bus.fifo_full;
  end

  assign bus.ready     = ready_c;
  assign bus.fifo_wren = accept;
  assign bus.fifo_din  = bus.data[int'(owner_q)*DWIDTH +: DWIDTH];
  assign bus.owner     = owner_q;
  assign bus.busy      = locked;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // Only a last beat releases the lock.
        if (accept && own_last) begin
          state_d = IDLE;
          prio_d  = IDXW'(next_idx(int'(owner_q), NREQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb.
// Producers replay per-port beat tables; FIFO writes are logged.
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]      pd   [NREQ][8];
  int              plen [NREQ];
  int              pptr [NREQ];
  logic            drop [NREQ];
  logic            full;
  logic [DW-1:0]   wq[$];

  logic [NREQ-1:0] s_ready;
  logic            s_wren;
  logic            s_busy;
  logic [1:0]      s_owner;
  logic [DW-1:0]   s_din;

  task automatic clear();
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 0;
      pptr[i] = 0;
      drop[i] = 1'b0;
    end
    full = 1'b0;
    wq.delete();
  endtask

  task automatic load(input int p, input logic [7:0] d,
                      input logic l);
    pd[p][plen[p]] = {l, d};
    plen[p]++;
  endtask

  // Drive at negedge, sample 1ns later, advance to next negedge.
  task automatic cycle();
    logic [NREQ-1:0]    r, l;
    logic [NREQ*DW-1:0] d;
    r = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pptr[i] < plen[i]) begin
        d[i*DW +: DW] = pd[i][pptr[i]][7:0];
        l[i]          = pd[i][pptr[i]][8];
        r[i]          = !drop[i];
      end
    end
    bus.req       = r;
    bus.last      = l;
    bus.data      = d;
    bus.fifo_full = full;
    #1;
    s_ready = bus.ready;
    s_wren  = bus.fifo_wren;
    s_busy  = bus.busy;
    s_owner = bus.owner;
    s_din   = bus.fifo_din;
    if (bus.fifo_wren) wq.push_back(bus.fifo_din);
    for (int i = 0; i < NREQ; i++)
      if (bus.ready[i] && r[i]) pptr[i]++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    bus.req       = '0;
    bus.last      = '0;
    bus.data      = '0;
    bus.fifo_full = 1'b0;
    clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.req       = '0;
    bus.last      = '0;
    bus.data      = 32'h4433_225A;
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready got %b want 0000", bus.ready);
    end
    checks++;
    if (bus.fifo_wren !== 1'b0) begin
      errors++;
      $display("FAIL rst_wren got %b want 0", bus.fifo_wren);
    end
    checks++;
    if (bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL rst_owner got %0d want 0", bus.owner);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.fifo_din !== 8'h5A) begin
      errors++;
      $display("FAIL rst_din got %h want 5a", bus.fifo_din);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_pkt();
    logic [7:0] ex [3];
    logic [7:0] lg [5];
    ex = '{8'h11, 8'h22, 8'h33};
    lg = '{8'h11, 8'h22, 8'h33, 8'h66, 8'h55};
    clear();
    load(2, 8'h11, 1'b0);
    load(2, 8'h22, 1'b0);
    load(2, 8'h33, 1'b1);
    cycle();
    checks++;
    if (s_busy !== 1'b0 || s_wren !== 1'b0) begin
      errors++;
      $display("FAIL sp_arb busy/wren got %b%b want 00",
               s_busy, s_wren);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (s_busy !== 1'b1 || s_wren !== 1'b1 ||
          s_owner !== 2'd2 || s_din !== ex[k]) begin
        errors++;
        $display("FAIL sp_beat%0d b/w/o/d got %b%b %0d %h want 11 2 %h",
                 k, s_busy, s_wren, s_owner, s_din, ex[k]);
      end
    end
    cycle();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL sp_idle busy got %b want 0", s_busy);
    end
    // prio now 3: producer 3 must beat producer 0.
    load(0, 8'h55, 1'b1);
    load(3, 8'h66, 1'b1);
    repeat (4) cycle();
    checks++;
    if (wq.size() != 5) begin
      errors++;
      $display("FAIL sp_logsize got %0d want 5", wq.size());
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ((k < wq.size() ? wq[k] : 8'hxx) !== lg[k]) begin
        errors++;
        $display("FAIL sp_log%0d got %h want %h",
                 k, (k < wq.size() ? wq[k] : 8'hxx), lg[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ex [8];
    ex = '{8'hA0, 8'hA1, 8'hA2, 8'hA3,
           8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    for (int i = 0; i < NREQ; i++)
      load(i, 8'hA0 + 8'(i), 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c == 8) begin
        for (int i = 0; i < NREQ; i++)
          load(i, 8'hA0 + 8'(i), 1'b1);
      end
      cycle();
      checks++;
      if (s_wren !== 1'(c % 2)) begin
        errors++;
        $display("FAIL rr_wren c%0d got %b want %0d",
                 c, s_wren, c % 2);
      end
      if (c % 2 == 1) begin
        checks++;
        if (s_owner !== 2'((c / 2) % 4)) begin
          errors++;
          $display("FAIL rr_owner c%0d got %0d want %0d",
                   c, s_owner, (c / 2) % 4);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ((k < wq.size() ? wq[k] : 8'hxx) !== ex[k]) begin
        errors++;
        $display("FAIL rr_log%0d got %h want %h",
                 k, (k < wq.size() ? wq[k] : 8'hxx), ex[k]);
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] ex [5];
    ex = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0};
    clear();
    for (int k = 0; k < 4; k++)
      load(0, 8'hB0 + 8'(k), k == 3);
    load(1, 8'hC0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (c < 6) begin
        checks++;
        if (s_ready[1] !== 1'b0) begin
          errors++;
          $display("FAIL il_ready1 c%0d got %b want 0",
                   c, s_ready[1]);
        end
      end
    end
    checks++;
    if (wq.size() != 5) begin
      errors++;
      $display("FAIL il_logsize got %0d want 5", wq.size());
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ((k < wq.size() ? wq[k] : 8'hxx) !== ex[k]) begin
        errors++;
        $display("FAIL il_log%0d got %h want %h",
                 k, (k < wq.size() ? wq[k] : 8'hxx), ex[k]);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] ex [4];
    ex = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    clear();
    for (int k = 0; k < 4; k++)
      load(1, 8'hD0 + 8'(k), k == 3);
    repeat (2) cycle();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_wren !== 1'b0 || s_ready[1] !== 1'b0 ||
          s_owner !== 2'd1 || s_busy !== 1'b1) begin
        errors++;
        $display("FAIL fl_stall c%0d w/r/o/b got %b%b %0d %b want 00 1 1",
                 c, s_wren, s_ready[1], s_owner, s_busy);
      end
    end
    full = 1'b0;
    repeat (4) cycle();
    checks++;
    if (wq.size() != 4) begin
      errors++;
      $display("FAIL fl_logsize got %0d want 4", wq.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ((k < wq.size() ? wq[k] : 8'hxx) !== ex[k]) begin
        errors++;
        $display("FAIL fl_log%0d got %h want %h",
                 k, (k < wq.size() ? wq[k] : 8'hxx), ex[k]);
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] ex [4];
    ex = '{8'hE0, 8'hE1, 8'hE2, 8'hF0};
    clear();
    for (int k = 0; k < 3; k++)
      load(0, 8'hE0 + 8'(k), k == 2);
    repeat (2) cycle();
    load(3, 8'hF0, 1'b1);
    drop[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (s_busy !== 1'b1 || s_wren !== 1'b0 ||
          s_ready[3] !== 1'b0 || s_owner !== 2'd0) begin
        errors++;
        $display("FAIL dr_hold c%0d b/w/r3/o got %b%b%b %0d want 100 0",
                 c, s_busy, s_wren, s_ready[3], s_owner);
      end
    end
    drop[0] = 1'b0;
    repeat (4) cycle();
    checks++;
    if (s_owner !== 2'd3 || s_wren !== 1'b1) begin
      errors++;
      $display("FAIL dr_next o/w got %0d %b want 3 1",
               s_owner, s_wren);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ((k < wq.size() ? wq[k] : 8'hxx) !== ex[k]) begin
        errors++;
        $display("FAIL dr_log%0d got %h want %h",
                 k, (k < wq.size() ? wq[k] : 8'hxx), ex[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear();
    load(0, 8'h70, 1'b1);
    repeat (2) cycle();
    for (int k = 0; k < 3; k++)
      load(1, 8'h80 + 8'(k), k == 2);
    repeat (2) cycle();
    checks++;
    if (s_owner !== 2'd1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre o/b got %0d %b want 1 1",
               s_owner, s_busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 4'b0000 ||
        bus.fifo_wren !== 1'b0 || bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL rm_rst b/r/w/o got %b %b %b %0d want 0 0000 0 0",
               bus.busy, bus.ready, bus.fifo_wren, bus.owner);
    end
    @(negedge clk);
    rstn = 1'b1;
    // prio was 1 before reset; a cleared prio serves producer 0 first.
    clear();
    load(0, 8'h90, 1'b1);
    load(1, 8'h91, 1'b1);
    repeat (4) cycle();
    checks++;
    if (wq.size() != 2 ||
        wq[0] !== 8'h90 || wq[1] !== 8'h91) begin
      errors++;
      $display("FAIL rm_after size %0d first %h want 2 90",
               wq.size(), (wq.size() > 0 ? wq[0] : 8'hxx));
    end
  endtask

  initial begin
    clear();
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_interleave();
    test_full();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
